l2_msg_ingress: RTL and testbench

- Ingress buffer on the L2 side of the CMP: captures the msg1 (request) and msg3 (response) channels that the L1.5/memory aggregation stage drives every cycle, and queues each in its own FIFO.
- Presents one message at a time to the L2 directory FSM over a valid/ready handshake.
- Responses take priority over requests to avoid protocol deadlock; a starvation guard bounds how long requests can wait.
- Upstream has no backpressure, so overflow is detected and flagged, never stalled.

---
 rtl/l2_msg_ingress.sv | 204 ++++++++++++++++++++
 tb/tb_l2_msg_ingress.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_msg_ingress.sv
// l2_msg_ingress: L2-side ingress buffer for the msg1 (request) and msg3 (response) channels.
// Each channel is captured into its own show-ahead FIFO. One message at a time is offered to
// the L2 directory FSM over a valid/ready handshake. Responses win over requests, and a
// starvation guard forces a request through after STARVE_LIMIT consecutive response grants.
// Upstream cannot be stalled, so a message that arrives at a full FIFO is dropped and a
// sticky overflow flag is raised.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   msg1_{type,data,tag,source}       request channel, type == MSG_TYPE_EMPTY means idle
//   msg3_{type,data,tag,source}       response channel, type == MSG_TYPE_EMPTY means idle
//   out_valid / out_ready             handshake towards the L2 directory FSM
//   out_chan                          0 = msg1, 1 = msg3
//   out_{type,data,tag,source}        presented message (EMPTY / 0 when !out_valid)
//   msg1_count, msg3_count            FIFO occupancies
//   msg1_ovf, msg3_ovf                sticky drop flags, cleared only by rst
//
// Build option: define L2_INGRESS_BYPASS_EN to let a message that arrives while both FIFOs
// are empty appear on out_* in the same cycle. Undefined (default), out_* depends only on
// registered state and the minimum latency is one cycle.

`ifndef MSG_WIDTH
`define MSG_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 8
`endif
`ifndef OWNER_BITS
`define OWNER_BITS 6
`endif
`ifndef MSG_TYPE_EMPTY
`define MSG_TYPE_EMPTY 8'd0
`endif

module l2_msg_ingress #(
    parameter int unsigned MSG1_DEPTH   = 4,
    parameter int unsigned MSG3_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [`MSG_WIDTH-1:0]         msg1_type,
    input  logic [`DATA_WIDTH-1:0]        msg1_data,
    input  logic [`TAG_WIDTH-1:0]         msg1_tag,
    input  logic [`OWNER_BITS-1:0]        msg1_source,
    input  logic [`MSG_WIDTH-1:0]         msg3_type,
    input  logic [`DATA_WIDTH-1:0]        msg3_data,
    input  logic [`TAG_WIDTH-1:0]         msg3_tag,
    input  logic [`OWNER_BITS-1:0]        msg3_source,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_chan,
    output logic [`MSG_WIDTH-1:0]         out_type,
    output logic [`DATA_WIDTH-1:0]        out_data,
    output logic [`TAG_WIDTH-1:0]         out_tag,
    output logic [`OWNER_BITS-1:0]        out_source,
    output logic [$clog2(MSG1_DEPTH):0]   msg1_count,
    output logic [$clog2(MSG3_DEPTH):0]   msg3_count,
    output logic                          msg1_ovf,
    output logic                          msg3_ovf
);

    localparam int unsigned EW  = `MSG_WIDTH + `DATA_WIDTH + `TAG_WIDTH + `OWNER_BITS;
    localparam int unsigned P1W = $clog2(MSG1_DEPTH);
    localparam int unsigned P3W = $clog2(MSG3_DEPTH);
    localparam int unsigned C1W = P1W + 1;
    localparam int unsigned C3W = P3W + 1;
    localparam int unsigned SW  = $clog2(STARVE_LIMIT + 1);

    typedef logic [EW-1:0] entry_t;

    entry_t           mem1 [MSG1_DEPTH];
    entry_t           mem3 [MSG3_DEPTH];
    logic [P1W-1:0]   rd1_q, wr1_q;
    logic [P3W-1:0]   rd3_q, wr3_q;
    logic [C1W-1:0]   cnt1_q;
    logic [C3W-1:0]   cnt3_q;
    logic             ovf1_q, ovf3_q;
    logic [SW-1:0]    starve_q;
    logic             lock_q;       // a presented message is waiting for out_ready
    logic             lock_chan_q;  // channel that message came from

    entry_t in1, in3, head;
    logic   in1_v, in3_v;
    logic   ne1, ne3, full1, full3, starved;
    logic   nat_chan, sel_chan, bypass, valid_c, fire;
    logic   deq1, deq3, take1, take3, wr1, wr3, drop1, drop3;

    assign in1   = {msg1_type, msg1_data, msg1_tag, msg1_source};
    assign in3   = {msg3_type, msg3_data, msg3_tag, msg3_source};
    assign in1_v = (msg1_type != `MSG_TYPE_EMPTY);
    assign in3_v = (msg3_type != `MSG_TYPE_EMPTY);

    assign ne1     = (cnt1_q != '0);
    assign ne3     = (cnt3_q != '0);
    assign full1   = (cnt1_q == C1W'(MSG1_DEPTH));
    assign full3   = (cnt3_q == C3W'(MSG3_DEPTH));
    assign starved = (starve_q == SW'(STARVE_LIMIT));

    // Responses first, unless requests have waited through STARVE_LIMIT response grants.
    assign nat_chan = ne3 && !(starved && ne1);

`ifdef L2_INGRESS_BYPASS_EN
    assign bypass = !ne1 && !ne3 && (in1_v || in3_v);
`else
    assign bypass = 1'b0;
`endif

    // A stalled presentation keeps its channel so out_* cannot change under the consumer.
    assign sel_chan = bypass ? in3_v : (lock_q ? lock_chan_q : nat_chan);

    always_comb begin
        head = '0;
        if (bypass) begin
            head = in3_v ? in3 : in1;
        end else if (sel_chan) begin
            head = mem3[rd3_q];
        end else begin
            head = mem1[rd1_q];
        end
    end

    assign valid_c = ne1 || ne3 || bypass;
    assign fire    = valid_c && out_ready;
    assign deq1    = fire && !bypass && !sel_chan;
    assign deq3    = fire && !bypass && sel_chan;

    // A bypassed message that is accepted immediately never touches its FIFO.
    assign take1 = in1_v && !(bypass && out_ready && !sel_chan);
    assign take3 = in3_v && !(bypass && out_ready && sel_chan);
    assign wr1   = take1 && (!full1 || deq1);
    assign wr3   = take3 && (!full3 || deq3);
    assign drop1 = take1 && full1 && !deq1;
    assign drop3 = take3 && full3 && !deq3;

    assign out_valid  = valid_c;
    assign out_chan   = valid_c ? sel_chan : 1'b0;
    assign out_type   = valid_c ? head[EW-1 -: `MSG_WIDTH] : `MSG_TYPE_EMPTY;
    assign out_data   = valid_c ? head[`TAG_WIDTH+`OWNER_BITS +: `DATA_WIDTH] : '0;
    assign out_tag    = valid_c ? head[`OWNER_BITS +: `TAG_WIDTH] : '0;
    assign out_source = valid_c ? head[0 +: `OWNER_BITS] : '0;
    assign msg1_count = cnt1_q;
    assign msg3_count = cnt3_q;
    assign msg1_ovf   = ovf1_q;
    assign msg3_ovf   = ovf3_q;

    // Storage is not reset; the pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && wr1) begin
            mem1[wr1_q] <= in1;
        end
        if (!rst && wr3) begin
            mem3[wr3_q] <= in3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_q       <= '0;
            wr1_q       <= '0;
            rd3_q       <= '0;
            wr3_q       <= '0;
            cnt1_q      <= '0;
            cnt3_q      <= '0;
            ovf1_q      <= 1'b0;
            ovf3_q      <= 1'b0;
            starve_q    <= '0;
            lock_q      <= 1'b0;
            lock_chan_q <= 1'b0;
        end else begin
            if (wr1) wr1_q <= wr1_q + P1W'(1);
            if (deq1) rd1_q <= rd1_q + P1W'(1);
            if (wr3) wr3_q <= wr3_q + P3W'(1);
            if (deq3) rd3_q <= rd3_q + P3W'(1);

            case ({wr1, deq1})
                2'b10:   cnt1_q <= cnt1_q + C1W'(1);
                2'b01:   cnt1_q <= cnt1_q - C1W'(1);
                default: cnt1_q <= cnt1_q;
            endcase
            case ({wr3, deq3})
                2'b10:   cnt3_q <= cnt3_q + C3W'(1);
                2'b01:   cnt3_q <= cnt3_q - C3W'(1);
                default: cnt3_q <= cnt3_q;
            endcase

            if (drop1) ovf1_q <= 1'b1;
            if (drop3) ovf3_q <= 1'b1;

            if (deq1 || !ne1) begin
                starve_q <= '0;
            end else if (deq3 && !starved) begin
                starve_q <= starve_q + SW'(1);
            end

            lock_q      <= valid_c && !out_ready;
            lock_chan_q <= sel_chan;
        end
    end

endmodule

// File: tb/tb_l2_msg_ingress.sv
// Self-checking bench for l2_msg_ingress (default build, bypass disabled).
// Per-channel scoreboards hold the messages in arrival order; each scenario also queues the
// channel sequence it expects the arbiter to grant.

`ifndef MSG_WIDTH
`define MSG_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 8
`endif
`ifndef OWNER_BITS
`define OWNER_BITS 6
`endif
`ifndef MSG_TYPE_EMPTY
`define MSG_TYPE_EMPTY 8'd0
`endif
`ifndef MSG_TYPE_LOAD_MEM_ACK
`define MSG_TYPE_LOAD_MEM_ACK 8'd24
`endif

module tb_l2_msg_ingress;

    localparam logic [`MSG_WIDTH-1:0] TReq = 8'd31;
    localparam logic [`MSG_WIDTH-1:0] TAck = `MSG_TYPE_LOAD_MEM_ACK;
    localparam int unsigned EW = `MSG_WIDTH + `DATA_WIDTH + `TAG_WIDTH + `OWNER_BITS;

    typedef logic [EW-1:0] ent_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [`MSG_WIDTH-1:0]  msg1_type, msg3_type, out_type;
    logic [`DATA_WIDTH-1:0] msg1_data, msg3_data, out_data;
    logic [`TAG_WIDTH-1:0]  msg1_tag, msg3_tag, out_tag;
    logic [`OWNER_BITS-1:0] msg1_source, msg3_source, out_source;
    logic                   out_valid, out_ready, out_chan;
    logic [2:0]             msg1_count, msg3_count;
    logic                   msg1_ovf, msg3_ovf;

    int   total = 0;
    int   bad   = 0;
    ent_t exp1_q[$];
    ent_t exp3_q[$];
    logic grant_q[$];

    always #5 clk = ~clk;

    l2_msg_ingress #(
        .MSG1_DEPTH  (4),
        .MSG3_DEPTH  (4),
        .STARVE_LIMIT(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .msg1_type  (msg1_type),
        .msg1_data  (msg1_data),
        .msg1_tag   (msg1_tag),
        .msg1_source(msg1_source),
        .msg3_type  (msg3_type),
        .msg3_data  (msg3_data),
        .msg3_tag   (msg3_tag),
        .msg3_source(msg3_source),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_chan   (out_chan),
        .out_type   (out_type),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_source (out_source),
        .msg1_count (msg1_count),
        .msg3_count (msg3_count),
        .msg1_ovf   (msg1_ovf),
        .msg3_ovf   (msg3_ovf)
    );

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic set1(input int tg, input logic [63:0] d, input int src, input bit keep);
        msg1_type   = TReq;
        msg1_tag    = 8'(tg);
        msg1_data   = d;
        msg1_source = 6'(src);
        if (keep) exp1_q.push_back({TReq, d, 8'(tg), 6'(src)});
    endtask

    task automatic set3(input int tg, input logic [63:0] d, input int src, input bit keep);
        msg3_type   = TAck;
        msg3_tag    = 8'(tg);
        msg3_data   = d;
        msg3_source = 6'(src);
        if (keep) exp3_q.push_back({TAck, d, 8'(tg), 6'(src)});
    endtask

    task automatic set1t(input int tg, input bit keep);
        set1(tg, 64'h1000 + 64'(tg), tg % 64, keep);
    endtask

    task automatic set3t(input int tg, input bit keep);
        set3(tg, 64'h3000_0000 + 64'(tg), (tg + 5) % 64, keep);
    endtask

    task automatic idle1();
        msg1_type = `MSG_TYPE_EMPTY; msg1_data = '0; msg1_tag = '0; msg1_source = '0;
    endtask

    task automatic idle3();
        msg3_type = `MSG_TYPE_EMPTY; msg3_data = '0; msg3_tag = '0; msg3_source = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle1();
        idle3();
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp1_q.delete();
        exp3_q.delete();
        grant_q.delete();
    endtask

    function automatic ent_t pop_exp(input logic ch);
        if (ch) begin
            if (exp3_q.size() != 0) return exp3_q.pop_front();
        end else if (exp1_q.size() != 0) begin
            return exp1_q.pop_front();
        end
        return '1;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        idle3();
        set1t(8'h77, 1'b0);  // must be ignored while rst is high
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle1();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (out_type !== `MSG_TYPE_EMPTY) begin bad++; $display("FAIL reset_type: got %h want %h", out_type, `MSG_TYPE_EMPTY); end
        total++; if ({out_chan, out_data, out_tag, out_source} !== '0) begin bad++; $display("FAIL reset_fields: got chan=%b data=%h tag=%h src=%h want 0", out_chan, out_data, out_tag, out_source); end
        total++; if (msg1_count !== 3'd0 || msg3_count !== 3'd0) begin bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", msg1_count, msg3_count); end
        total++; if (msg1_ovf !== 1'b0 || msg3_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b/%b want 0/0", msg1_ovf, msg3_ovf); end
    endtask

    task automatic test_single();
        logic ec;
        ent_t ee;
        set1(3, 64'h5A, 1, 1'b1);
        grant_q.push_back(1'b0);
        @(negedge clk);
        idle1();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_latency: got valid=%b want 1", out_valid); end
        for (int c = 0; c < 10 && grant_q.size() != 0; c++) begin
            if (out_valid && out_ready) begin
                ec = grant_q.pop_front();
                ee = pop_exp(ec);
                total++;
                if ({out_chan, out_type, out_data, out_tag, out_source} !== {ec, ee}) begin
                    bad++; $display("FAIL single_msg: got %h want %h", {out_chan, out_type, out_data, out_tag, out_source}, {ec, ee});
                end
            end
            @(negedge clk);
        end
        total++; if (grant_q.size() != 0 || exp1_q.size() != 0) begin bad++; $display("FAIL single_timeout: got %0d left want 0", grant_q.size()); grant_q.delete(); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_after: got valid=%b want 0", out_valid); end
    endtask

    task automatic test_priority();
        logic ec;
        ent_t ee;
        set1t(1, 1'b1);
        set3t(2, 1'b1);
        grant_q.push_back(1'b1);
        grant_q.push_back(1'b0);
        @(negedge clk);
        idle1();
        idle3();
        for (int c = 0; c < 10 && grant_q.size() != 0; c++) begin
            if (out_valid && out_ready) begin
                ec = grant_q.pop_front();
                ee = pop_exp(ec);
                total++;
                if ({out_chan, out_type, out_data, out_tag, out_source} !== {ec, ee}) begin
                    bad++; $display("FAIL priority_msg: got %h want %h", {out_chan, out_type, out_data, out_tag, out_source}, {ec, ee});
                end
            end
            @(negedge clk);
        end
        total++; if (grant_q.size() != 0 || exp1_q.size() != 0 || exp3_q.size() != 0) begin bad++; $display("FAIL priority_timeout: got %0d left want 0", grant_q.size()); grant_q.delete(); end
    endtask

    task automatic test_overflow();
        logic ec;
        ent_t ee;
        ent_t m3;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                total++;
                if (out_valid !== 1'b1 || out_tag !== 8'd0) begin bad++; $display("FAIL ovf_hold: got valid=%b tag=%0d want 1/0", out_valid, out_tag); end
            end
            set1t(i, i < 4);  // the fifth request finds the FIFO full and is lost
            @(negedge clk);
        end
        total++; if (msg1_count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", msg1_count); end
        total++; if (msg1_ovf !== 1'b1 || msg3_ovf !== 1'b0) begin bad++; $display("FAIL ovf_flag: got %b/%b want 1/0", msg1_ovf, msg3_ovf); end
        idle1();
        set3t(9, 1'b0);
        m3 = {TAck, 64'h3000_0000 + 64'd9, 8'd9, 6'd14};
        exp3_q.push_back(m3);
        @(negedge clk);
        idle3();
        total++; if (out_chan !== 1'b0 || out_tag !== 8'd0) begin bad++; $display("FAIL ovf_lock: got chan=%b tag=%0d want 0/0", out_chan, out_tag); end
        total++; if (msg3_count !== 3'd1) begin bad++; $display("FAIL ovf_m3count: got %0d want 1", msg3_count); end
        grant_q.push_back(1'b0);
        grant_q.push_back(1'b1);
        grant_q.push_back(1'b0);
        grant_q.push_back(1'b0);
        grant_q.push_back(1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && grant_q.size() != 0; c++) begin
            if (out_valid && out_ready) begin
                ec = grant_q.pop_front();
                ee = pop_exp(ec);
                total++;
                if ({out_chan, out_type, out_data, out_tag, out_source} !== {ec, ee}) begin
                    bad++; $display("FAIL ovf_drain: got %h want %h", {out_chan, out_type, out_data, out_tag, out_source}, {ec, ee});
                end
            end
            @(negedge clk);
        end
        total++; if (grant_q.size() != 0 || exp1_q.size() != 0 || exp3_q.size() != 0 || out_valid !== 1'b0) begin bad++; $display("FAIL ovf_timeout: got %0d left valid=%b want 0/0", grant_q.size(), out_valid); grant_q.delete(); end
        total++; if (msg1_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", msg1_ovf); end
    endtask

    task automatic test_reset_mid();
        logic ec;
        ent_t ee;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set1t(40 + i, 1'b0);
            set3t(50 + i, 1'b0);
            @(negedge clk);
        end
        total++; if (msg1_count !== 3'd2 || msg3_count !== 3'd2) begin bad++; $display("FAIL rmid_fill: got %0d/%0d want 2/2", msg1_count, msg3_count); end
        rst = 1'b1;
        set1t(60, 1'b0);
        set3t(61, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle1();
        idle3();
        out_ready = 1'b1;
        total++; if (msg1_count !== 3'd0 || msg3_count !== 3'd0) begin bad++; $display("FAIL rmid_counts: got %0d/%0d want 0/0", msg1_count, msg3_count); end
        total++; if (out_valid !== 1'b0 || msg1_ovf !== 1'b0 || msg3_ovf !== 1'b0) begin bad++; $display("FAIL rmid_state: got valid=%b ovf=%b/%b want 0/0/0", out_valid, msg1_ovf, msg3_ovf); end
        set1t(7, 1'b1);
        grant_q.push_back(1'b0);
        @(negedge clk);
        idle1();
        for (int c = 0; c < 10 && grant_q.size() != 0; c++) begin
            if (out_valid && out_ready) begin
                ec = grant_q.pop_front();
                ee = pop_exp(ec);
                total++;
                if ({out_chan, out_type, out_data, out_tag, out_source} !== {ec, ee}) begin
                    bad++; $display("FAIL rmid_msg: got %h want %h", {out_chan, out_type, out_data, out_tag, out_source}, {ec, ee});
                end
            end
            @(negedge clk);
        end
        total++; if (grant_q.size() != 0 || out_valid !== 1'b0) begin bad++; $display("FAIL rmid_timeout: got %0d left valid=%b want 0/0", grant_q.size(), out_valid); grant_q.delete(); end
    endtask

    task automatic test_full_deq();
        logic ec;
        ent_t ee;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set1t(10 + i, 1'b1);
            @(negedge clk);
        end
        total++; if (msg1_count !== 3'd4) begin bad++; $display("FAIL fulldeq_fill: got %0d want 4", msg1_count); end
        // Full and popped in the same cycle: the new request must be accepted.
        out_ready = 1'b1;
        set1t(14, 1'b1);
        for (int i = 0; i < 5; i++) grant_q.push_back(1'b0);
        for (int c = 0; c < 20 && grant_q.size() != 0; c++) begin
            if (c == 1) begin
                idle1();
                total++;
                if (msg1_count !== 3'd4 || msg1_ovf !== 1'b0) begin bad++; $display("FAIL fulldeq_count: got %0d ovf=%b want 4/0", msg1_count, msg1_ovf); end
            end
            if (out_valid && out_ready) begin
                ec = grant_q.pop_front();
                ee = pop_exp(ec);
                total++;
                if ({out_chan, out_type, out_data, out_tag, out_source} !== {ec, ee}) begin
                    bad++; $display("FAIL fulldeq_msg: got %h want %h", {out_chan, out_type, out_data, out_tag, out_source}, {ec, ee});
                end
            end
            @(negedge clk);
        end
        total++; if (grant_q.size() != 0 || exp1_q.size() != 0 || out_valid !== 1'b0) begin bad++; $display("FAIL fulldeq_timeout: got %0d left valid=%b want 0/0", grant_q.size(), out_valid); grant_q.delete(); end
    endtask

    task automatic test_starvation();
        logic ec;
        ent_t ee;
        logic plan [10] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1};
        do_reset();
        foreach (plan[i]) grant_q.push_back(plan[i]);
        set1t(20, 1'b1);
        set3t(30, 1'b1);
        @(negedge clk);
        for (int c = 0; c < 30 && grant_q.size() != 0; c++) begin
            if (out_valid && out_ready) begin
                ec = grant_q.pop_front();
                ee = pop_exp(ec);
                total++;
                if ({out_chan, out_type, out_data, out_tag, out_source} !== {ec, ee}) begin
                    bad++; $display("FAIL starve_grant%0d: got %h want %h", c, {out_chan, out_type, out_data, out_tag, out_source}, {ec, ee});
                end
            end
            if (c == 0) set1t(21, 1'b1); else idle1();
            if (c < 7) set3t(31 + c, 1'b1); else idle3();
            @(negedge clk);
        end
        total++; if (grant_q.size() != 0 || exp1_q.size() != 0 || exp3_q.size() != 0 || out_valid !== 1'b0) begin bad++; $display("FAIL starve_timeout: got %0d left valid=%b want 0/0", grant_q.size(), out_valid); grant_q.delete(); end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        idle1();
        idle3();
        @(negedge clk);
        test_reset();
        test_single();
        test_priority();
        test_overflow();
        test_reset_mid();
        test_full_deq();
        test_starvation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
